uart_rx_fifo: RTL and testbench

Serial receive front end for the core's UART port. Oversamples the `rxd` pin, deserialises 8N1 frames, and buffers bytes in a show-ahead FIFO. The FIFO drives the core's `uart_empty` / `uart_in` inputs and is popped by the core's `uart_rdreq` output. It sits directly upstream of the memory-mapped UART read path of the core.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/uart_rx_fifo.sv | 121 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Imported by the receive front end and its FIFO.
package uart_pkg;

  localparam int UART_DATA_W      = 8;
  localparam int DEF_CLKS_PER_BIT = 434;
  localparam int DEF_DEPTH        = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead FIFO, head word visible on dout.
// Level counter is kept apart from the wrapping pointers.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_pop;
  logic             w_push;

  assign empty  = (r_level == '0);
  assign full   = (r_level == LW'(DEPTH));
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign level  = r_level;
  assign dout   = empty ? '0 : r_mem[r_rptr];

  // storage write, no reset needed on the array
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a show-ahead byte FIFO.
// Samples mid-bit, counted from the first low seen on the synchronised line.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DEPTH        = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rxd,
  input  logic                   uart_rdreq,
  output logic [UART_DATA_W-1:0] uart_in,
  output logic                   uart_empty,
  output logic [$clog2(DEPTH):0] rx_level,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]             r_sync;
  rx_state_t              r_state;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_idx;
  logic [UART_DATA_W-1:0] r_shift;
  logic                   r_frame_err;
  logic                   r_overrun;
  logic                   w_rxd_s;
  logic                   w_stop_tick;
  logic                   w_push_req;
  logic                   w_pop_ok;
  logic                   w_full;

  assign w_rxd_s     = r_sync[1];
  assign w_stop_tick = (r_state == STOP) && (r_cnt == LAST);
  assign w_push_req  = w_stop_tick & w_rxd_s;
  assign w_pop_ok    = uart_rdreq & ~uart_empty;
  assign frame_err   = r_frame_err;
  assign overrun     = r_overrun;

  // two-flop synchroniser, idles high
  always_ff @(posedge clk) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], rxd};
  end

  // frame receiver: start check at half bit, then one full bit per sample
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!w_rxd_s) r_state <= START;
        end
        START: begin
          if (r_cnt == MID) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= w_rxd_s ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == LAST) begin
            r_shift[r_idx] <= w_rxd_s;
            r_cnt          <= '0;
            r_idx          <= r_idx + 1'b1;
            if (r_idx == 3'd7) r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // framing error pulse and sticky overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_tick & ~w_rxd_s;
      if (w_push_req && w_full && !w_pop_ok) r_overrun <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push_req),
    .pop   (uart_rdreq),
    .din   (r_shift),
    .dout  (uart_in),
    .empty (uart_empty),
    .full  (w_full),
    .level (rx_level)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at C=8, DEPTH=4.
// Frames are bit-banged on rxd; outputs sampled 1 time unit after clk rises.
module tb_uart_rx_fifo;

  localparam int C = 8;
  localparam int H = C / 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       uart_rdreq = 1'b0;
  logic [7:0] uart_in;
  logic       uart_empty;
  logic [2:0] rx_level;
  logic       frame_err;
  logic       overrun;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLKS_PER_BIT (C),
    .DEPTH        (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .uart_rdreq (uart_rdreq),
    .uart_in    (uart_in),
    .uart_empty (uart_empty),
    .rx_level   (rx_level),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rxd = 1'b1;
    uart_rdreq = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pop_one();
    uart_rdreq = 1'b1;
    step();
    uart_rdreq = 1'b0;
  endtask

  // drives one 10-bit frame; n counts edges from the pin fall
  task automatic send_frame(
    input  logic [7:0]  d,
    input  logic        stopb,
    input  logic        pop_stop,
    input  int          rst_at,
    output int          first_ne,
    output int          fe_cnt,
    output int          fe_at,
    output logic [15:0] snap
  );
    int b;
    first_ne = -1;
    fe_cnt   = 0;
    fe_at    = -1;
    snap     = '0;
    for (int n = 0; n < 10 * C; n++) begin
      b = n / C;
      if (b == 0)      rxd = 1'b0;
      else if (b == 9) rxd = stopb;
      else             rxd = d[b-1];
      uart_rdreq = pop_stop && (n == H + 2 + 9 * C);
      rst = (n == rst_at);
      step();
      if (!uart_empty && first_ne < 0) first_ne = n + 1;
      if (frame_err) begin
        fe_cnt++;
        if (fe_at < 0) fe_at = n + 1;
      end
      if (n == rst_at)
        snap = {uart_empty, frame_err, overrun, 2'b00, rx_level, uart_in};
    end
    rxd = 1'b1;
    uart_rdreq = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (uart_empty !== 1'b1) $display("FAIL rst_empty got %b want 1", uart_empty);
    else passed++;
    total++;
    if (uart_in !== 8'h00) $display("FAIL rst_in got %h want 00", uart_in);
    else passed++;
    total++;
    if (rx_level !== 3'd0) $display("FAIL rst_level got %0d want 0", rx_level);
    else passed++;
    total++;
    if (frame_err !== 1'b0) $display("FAIL rst_fe got %b want 0", frame_err);
    else passed++;
    total++;
    if (overrun !== 1'b0) $display("FAIL rst_ovr got %b want 0", overrun);
    else passed++;
  endtask

  task automatic test_single();
    int fn, fc, fa;
    logic [15:0] s;
    do_reset();
    send_frame(8'hA5, 1'b1, 1'b0, -1, fn, fc, fa, s);
    total++;
    if (fn !== 79) $display("FAIL a5_latency got %0d want 79", fn);
    else passed++;
    total++;
    if (uart_in !== 8'hA5) $display("FAIL a5_data got %h want a5", uart_in);
    else passed++;
    total++;
    if (rx_level !== 3'd1) $display("FAIL a5_level got %0d want 1", rx_level);
    else passed++;
    total++;
    if (fc !== 0) $display("FAIL a5_fe got %0d want 0", fc);
    else passed++;
    pop_one();
    total++;
    if (uart_empty !== 1'b1 || uart_in !== 8'h00)
      $display("FAIL a5_pop got e=%b d=%h want e=1 d=00", uart_empty, uart_in);
    else passed++;
  endtask

  task automatic test_overrun();
    int fn, fc, fa;
    logic [15:0] s;
    logic [7:0] exp;
    do_reset();
    for (int i = 1; i <= 5; i++)
      send_frame(8'(i), 1'b1, 1'b0, -1, fn, fc, fa, s);
    total++;
    if (rx_level !== 3'd4) $display("FAIL ovr_level got %0d want 4", rx_level);
    else passed++;
    total++;
    if (overrun !== 1'b1) $display("FAIL ovr_flag got %b want 1", overrun);
    else passed++;
    for (int i = 1; i <= 4; i++) begin
      exp = 8'(i);
      total++;
      if (uart_in !== exp) $display("FAIL ovr_pop%0d got %h want %h", i, uart_in, exp);
      else passed++;
      pop_one();
    end
    total++;
    if (uart_empty !== 1'b1 || uart_in !== 8'h00)
      $display("FAIL ovr_drain got e=%b d=%h want e=1 d=00", uart_empty, uart_in);
    else passed++;
    total++;
    if (overrun !== 1'b1) $display("FAIL ovr_sticky got %b want 1", overrun);
    else passed++;
  endtask

  task automatic test_frame_err();
    int fn, fc, fa;
    logic [15:0] s;
    do_reset();
    send_frame(8'h3C, 1'b0, 1'b0, -1, fn, fc, fa, s);
    for (int i = 0; i < 4; i++) begin
      step();
      if (frame_err) fc++;
    end
    total++;
    if (fc !== 1) $display("FAIL fe_count got %0d want 1", fc);
    else passed++;
    total++;
    if (fa !== 79) $display("FAIL fe_time got %0d want 79", fa);
    else passed++;
    total++;
    if (rx_level !== 3'd0 || overrun !== 1'b0)
      $display("FAIL fe_nopush got lvl=%0d ovr=%b want 0 0", rx_level, overrun);
    else passed++;
  endtask

  task automatic test_glitch();
    int fn, fc, fa;
    logic [15:0] s;
    int g;
    do_reset();
    g = 0;
    rxd = 1'b0;
    step();
    step();
    rxd = 1'b1;
    for (int i = 0; i < 3 * C; i++) begin
      step();
      if (frame_err || !uart_empty) g++;
    end
    total++;
    if (g !== 0 || rx_level !== 3'd0)
      $display("FAIL glitch got ev=%0d lvl=%0d want 0 0", g, rx_level);
    else passed++;
    send_frame(8'h5A, 1'b1, 1'b0, -1, fn, fc, fa, s);
    total++;
    if (uart_in !== 8'h5A || rx_level !== 3'd1)
      $display("FAIL glitch_next got %h/%0d want 5a/1", uart_in, rx_level);
    else passed++;
  endtask

  task automatic test_pop_at_full();
    int fn, fc, fa;
    logic [15:0] s;
    logic [7:0] exp [4];
    exp = '{8'h22, 8'h33, 8'h44, 8'h77};
    do_reset();
    send_frame(8'h11, 1'b1, 1'b0, -1, fn, fc, fa, s);
    send_frame(8'h22, 1'b1, 1'b0, -1, fn, fc, fa, s);
    send_frame(8'h33, 1'b1, 1'b0, -1, fn, fc, fa, s);
    send_frame(8'h44, 1'b1, 1'b0, -1, fn, fc, fa, s);
    send_frame(8'h77, 1'b1, 1'b1, -1, fn, fc, fa, s);
    total++;
    if (rx_level !== 3'd4) $display("FAIL full_level got %0d want 4", rx_level);
    else passed++;
    total++;
    if (overrun !== 1'b0) $display("FAIL full_ovr got %b want 0", overrun);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (uart_in !== exp[i]) $display("FAIL full_pop%0d got %h want %h", i, uart_in, exp[i]);
      else passed++;
      pop_one();
    end
    total++;
    if (uart_empty !== 1'b1) $display("FAIL full_drain got %b want 1", uart_empty);
    else passed++;
  endtask

  task automatic test_reset_midframe();
    int fn, fc, fa;
    logic [15:0] s;
    do_reset();
    send_frame(8'h99, 1'b1, 1'b0, -1, fn, fc, fa, s);
    total++;
    if (rx_level !== 3'd1) $display("FAIL mid_pre got %0d want 1", rx_level);
    else passed++;
    send_frame(8'hFA, 1'b1, 1'b0, 4 * C + 3, fn, fc, fa, s);
    total++;
    if (s !== 16'h8000) $display("FAIL mid_snap got %h want 8000", s);
    else passed++;
    step();
    total++;
    if (uart_empty !== 1'b1 || rx_level !== 3'd0 || fc !== 0)
      $display("FAIL mid_nopush got e=%b lvl=%0d fe=%0d want 1 0 0",
               uart_empty, rx_level, fc);
    else passed++;
    send_frame(8'hC3, 1'b1, 1'b0, -1, fn, fc, fa, s);
    total++;
    if (uart_in !== 8'hC3 || rx_level !== 3'd1)
      $display("FAIL mid_next got %h/%0d want c3/1", uart_in, rx_level);
    else passed++;
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_pop_at_full();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
